// File: rtl/clk_en_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_pkg
// Shared definitions for the clock-enable generator:
//   mode_e  - per-channel mode encoding (OFF / RUN / STEP / reserved)
//   ch_w()  - width of the channel-select field for a given channel count
// -----------------------------------------------------------------------------
package clk_en_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // At least one select bit, even for a single channel.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// -----------------------------------------------------------------------------
// clk_en_chan
// One clock-enable channel: holds mode, divisor, counter, previous step level,
// the one-cycle enable pulse and the divided square wave.
// Ports:
//   clk, rst_n    board clock, synchronous active-low reset
//   we_i          configuration write aimed at this channel
//   mode_i/div_i  new mode and divisor, loaded when we_i is high
//   step_i        synchronised single-step request
//   ce_o          registered one-cycle enable pulse
//   clk_sq_o      registered square wave, toggles with every ce pulse
//   running_o     registered, high while the mode is RUN
// -----------------------------------------------------------------------------
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int unsigned      DIV_W    = 24,
  parameter logic [DIV_W-1:0] DIV_RST  = '0,
  parameter logic [1:0]       MODE_RST = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  mode_e            mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             step_i,
  output logic             ce_o,
  output logic             clk_sq_o,
  output logic             running_o
);

  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             step_q;
  logic             ce_q, ce_d;
  logic             sq_q, sq_d;
  logic             run_q, run_d;

  always_comb begin
    mode_d = mode_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    ce_d   = 1'b0;
    sq_d   = sq_q;

    if (we_i) begin
      // A write takes priority, so a coincident step edge is dropped.
      mode_d = mode_i;
      div_d  = div_i;
      cnt_d  = '0;
      if (mode_i != MODE_RUN && mode_i != MODE_STEP) sq_d = 1'b0;
    end else begin
      unique case (mode_q)
        MODE_RUN: begin
          // >= keeps the counter bounded even if it ever exceeds div.
          if (cnt_q >= div_q) begin
            ce_d  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        MODE_STEP: begin
          cnt_d = '0;
          ce_d  = step_i & ~step_q;
        end
        default: begin
          cnt_d = '0;
          sq_d  = 1'b0;
        end
      endcase
    end

    if (ce_d) sq_d = ~sq_q;
    run_d = (mode_d == MODE_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= mode_e'(MODE_RST);
      div_q  <= DIV_RST;
      cnt_q  <= '0;
      step_q <= 1'b0;
      ce_q   <= 1'b0;
      sq_q   <= 1'b0;
      run_q  <= (MODE_RST == MODE_RUN);
    end else begin
      mode_q <= mode_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      step_q <= step_i;
      ce_q   <= ce_d;
      sq_q   <= sq_d;
      run_q  <= run_d;
    end
  end

  assign ce_o      = ce_q;
  assign clk_sq_o  = sq_q;
  assign running_o = run_q;

endmodule

// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen
// Multi-channel clock-enable generator in the board clock domain. Each channel
// is OFF, free-running divide-by-(D+1), or single-step. The top level only
// decodes the configuration channel select into per-channel write enables.
// Ports:
//   clk, rst_n   board clock, synchronous active-low reset
//   cfg_we       configuration write strobe
//   cfg_ch       channel to configure (values >= NUM_CH are ignored)
//   cfg_mode     00 OFF, 01 RUN, 10 STEP, 11 reserved (acts as OFF)
//   cfg_div      divisor D, RUN period is D+1 cycles
//   step         per-channel step requests
//   ce           per-channel one-cycle enable pulses
//   clk_sq       per-channel divided square waves
//   running      per-channel RUN indication
// -----------------------------------------------------------------------------
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int unsigned      NUM_CH   = 2,
  parameter int unsigned      DIV_W    = 24,
  parameter logic [DIV_W-1:0] DIV_RST  = '0,
  parameter logic [1:0]       MODE_RST = 2'b01,
  localparam int unsigned     CH_W     = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] step,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_sq,
  output logic [NUM_CH-1:0] running
);

  logic [NUM_CH-1:0] ch_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    assign ch_we[i] = cfg_we & (cfg_ch == IDX);

    clk_en_chan #(
      .DIV_W    (DIV_W),
      .DIV_RST  (DIV_RST),
      .MODE_RST (MODE_RST)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (ch_we[i]),
      .mode_i    (mode_e'(cfg_mode)),
      .div_i     (cfg_div),
      .step_i    (step[i]),
      .ce_o      (ce[i]),
      .clk_sq_o  (clk_sq[i]),
      .running_o (running[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_en_gen
// Directed bench for clk_en_gen with NUM_CH=3, DIV_W=4. Expected values are
// hand-derived from the reset/config/RUN/STEP timing rules.
// -----------------------------------------------------------------------------
module tb_clk_en_gen;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_div;
  logic [2:0] step;
  logic [2:0] ce;
  logic [2:0] clk_sq;
  logic [2:0] running;

  int checks   = 0;
  int failures = 0;

  clk_en_gen #(
    .NUM_CH   (3),
    .DIV_W    (4),
    .DIV_RST  (4'd0),
    .MODE_RST (2'b01)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_div  (cfg_div),
    .step     (step),
    .ce       (ce),
    .clk_sq   (clk_sq),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] dv);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_mode = mode;
    cfg_div  = dv;
  endtask

  logic [12:0] stp_pat;
  logic [12:0] ce_pat;
  int          pulses;

  initial begin
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = 2'd0;
    cfg_mode = 2'b00;
    cfg_div  = 4'd0;
    step     = 3'b000;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ce", 32'(ce), 32'h0);
      check("rst_sq", 32'(clk_sq), 32'h0);
      check("rst_running", 32'(running), 32'h7);
    end
    rst_n = 1'b1;

    // Default RUN with D=0: enable every cycle, square wave every cycle.
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("dflt_ce", 32'(ce), 32'h7);
      check("dflt_sq", 32'(clk_sq), (k % 2 == 1) ? 32'h7 : 32'h0);
    end

    // ch0 RUN D=4; ch1 must keep toggling every cycle.
    write_cfg(2'd0, 2'b01, 4'd4);
    tick();
    cfg_we = 1'b0;
    check("d4_wr_ce0", 32'(ce[0]), 32'h0);
    check("d4_wr_sq0", 32'(clk_sq[0]), 32'h0);
    for (int k = 1; k <= 50; k++) begin
      tick();
      check("d4_ce0", 32'(ce[0]), (k % 5 == 0) ? 32'h1 : 32'h0);
      check("d4_sq0", 32'(clk_sq[0]), ((k / 5) % 2 == 1) ? 32'h1 : 32'h0);
      check("d4_ce1", 32'(ce[1]), 32'h1);
      check("d4_sq1", 32'(clk_sq[1]), (k % 2 == 0) ? 32'h1 : 32'h0);
    end

    // ch1 STEP: 7-cycle hold, then two single-cycle pulses -> 3 enables.
    write_cfg(2'd1, 2'b10, 4'd0);
    tick();
    cfg_we = 1'b0;
    check("stp_wr_ce1", 32'(ce[1]), 32'h0);
    check("stp_running", 32'(running), 32'h5);
    check("stp_wr_sq1", 32'(clk_sq[1]), 32'h1);
    stp_pat = 13'b0100101111111;
    ce_pat  = 13'b0100100000001;
    pulses  = 0;
    for (int i = 0; i < 13; i++) begin
      step[1] = stp_pat[i];
      tick();
      check("stp_ce1", 32'(ce[1]), 32'(ce_pat[i]));
      if (ce[1] === 1'b1) pulses++;
    end
    check("stp_pulses", 32'(pulses), 32'd3);
    check("stp_sq1", 32'(clk_sq[1]), 32'h0);
    check("stp_run1", 32'(running[1]), 32'h0);

    // Step edge coincident with a write to ch0 is dropped.
    write_cfg(2'd0, 2'b10, 4'd0);
    step[0] = 1'b1;
    tick();
    cfg_we = 1'b0;
    check("coin_wr_ce0", 32'(ce[0]), 32'h0);
    check("coin_running", 32'(running), 32'h4);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("coin_ce0", 32'(ce[0]), 32'h0);
    end

    // Write to cfg_ch=NUM_CH is ignored.
    write_cfg(2'd3, 2'b01, 4'd0);
    tick();
    cfg_we = 1'b0;
    check("oor_running", 32'(running), 32'h4);
    check("oor_ce", 32'(ce), 32'h4);
    step[0] = 1'b0;
    tick();
    check("oor_ce0_lo", 32'(ce[0]), 32'h0);
    step[0] = 1'b1;
    tick();
    check("oor_ce0_step", 32'(ce[0]), 32'h1);
    step[0] = 1'b0;

    // ch0 RUN at maximum divisor: period 16 without wrap glitches.
    write_cfg(2'd0, 2'b01, 4'd15);
    tick();
    cfg_we = 1'b0;
    check("d15_wr_ce0", 32'(ce[0]), 32'h0);
    for (int k = 1; k <= 41; k++) begin
      tick();
      check("d15_ce0", 32'(ce[0]), (k % 16 == 0) ? 32'h1 : 32'h0);
    end

    // Reset with cnt=9 restores defaults.
    rst_n = 1'b0;
    tick();
    check("mid_rst_ce", 32'(ce), 32'h0);
    check("mid_rst_sq", 32'(clk_sq), 32'h0);
    check("mid_rst_running", 32'(running), 32'h7);
    rst_n = 1'b1;
    tick();
    check("post_rst_ce", 32'(ce), 32'h7);
    check("post_rst_sq", 32'(clk_sq), 32'h7);

    // RUN -> OFF while clk_sq[0]=1, then RUN D=1.
    write_cfg(2'd0, 2'b00, 4'd0);
    tick();
    check("off_ce0", 32'(ce[0]), 32'h0);
    check("off_sq0", 32'(clk_sq[0]), 32'h0);
    check("off_run0", 32'(running[0]), 32'h0);
    write_cfg(2'd0, 2'b01, 4'd1);
    tick();
    cfg_we = 1'b0;
    check("d1_wr_ce0", 32'(ce[0]), 32'h0);
    check("d1_wr_sq0", 32'(clk_sq[0]), 32'h0);
    check("d1_run0", 32'(running[0]), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("d1_ce0", 32'(ce[0]), (k % 2 == 0) ? 32'h1 : 32'h0);
      check("d1_sq0", 32'(clk_sq[0]), ((k / 2) % 2 == 1) ? 32'h1 : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
